d_ctl: RTL and testbench
========================

# d_ctl

Sequencer and arbiter for the 10-bit D register load path. Three requesters share D: a clear request, a byte load from the low byte of W, and an ALU result capture that may repeat for up to 2^ALU_N_W consecutive cycles for iterative steps. d_ctl grants one requester at a time and drives the D register's source select, load strobe and clear strobe. All outputs are registered.

## Interface

- ALU_N_W, 4, width of the ALU repeat-count input; an ALU sequence lasts alu_n+1 cycles.

- clk_sys  in  1  system clock, rising edge.
- _rst  in  1  asynchronous, active-low reset.
- clr_req  in  1  level request to clear D; held until clr_ack.
- byte_req  in  1  level request to load D from W[8:15] (sign-extended); held until byte_ack.
- alu_req  in  1  level request to capture the ALU sum into D; held until alu_ack.
- alu_n  in  [0:ALU_N_W-1]  ALU repeat count, MSB-first; sampled only on the ALU grant edge.
- clr_ack  out  1  one-cycle pulse, clear done.
- byte_ack  out  1  one-cycle pulse, byte load done.
- alu_ack  out  1  one-cycle pulse, last ALU capture done.
- lkb  out  1  D source select: 1 selects W byte, 0 selects ALU sum.
- l_d  out  1  D load strobe.
- clr_d  out  1  D clear strobe, active-high.
- busy  out  1  high when the FSM is not in IDLE.

## Operation

- States: IDLE, CLR, BYTE, ALU.
- IDLE: all strobes and acks are 0. On each edge the FSM samples the requests:
  - clr_req wins over everything else; next state is CLR.
  - Otherwise, if exactly one of byte_req and alu_req is high, that one is granted.
  - If both are high, the one not granted last time wins. A 1-bit `last` flag tracks this: it is set on a BYTE grant and cleared on an ALU grant. After reset, ALU has preference.
- CLR: clr_d=1 and clr_ack=1 for one cycle, then IDLE.
- BYTE: lkb=1, l_d=1 and byte_ack=1 for one cycle, then IDLE.
- ALU: on the grant edge, alu_n is loaded into a down-counter.
  - l_d=1 and lkb=0 every cycle while in ALU.
  - The counter decrements each cycle. alu_ack=1 in the cycle where the counter equals 0, then IDLE.
  - alu_n=0 gives a single capture; all-ones gives 2^ALU_N_W captures.
- No preemption: requests arriving during a sequence, including clr_req, wait until IDLE.
- lkb holds its last value outside BYTE and ALU. Its value is only relevant while l_d=1.
- Exactly one of clr_d and l_d may be high in any cycle. They are never high together.

## Timing

- Reset: asynchronous on _rst low. State goes to IDLE, counter to 0, `last` to 0, and every output (lkb, l_d, clr_d, all acks, busy) to 0.
  - Reset asserted mid-sequence aborts it immediately. No ack is issued.
  - Requesters must treat reset as cancelling their request.
- Latency: a request high at edge N (FSM in IDLE) produces its strobe and ack in the cycle after edge N. busy also rises in that cycle.
- Handshake: the requester deasserts its request at the edge where it samples its ack high.
  - The FSM returns to IDLE on that same edge, so the request is low when IDLE next samples.
  - A request still high at that IDLE sample is treated as a new request.
- Throughput: a single-cycle operation (CLR or BYTE) occupies 2 cycles: op cycle plus IDLE cycle. An ALU sequence occupies alu_n+2 cycles.
- A request deasserted before its grant is simply not served. No ack is issued.
- alu_n changes after the grant edge have no effect on the sequence in progress.

## Test plan

- Reset: hold _rst low, toggle all requests → every output stays 0. Release reset with byte_req and alu_req both high → ALU granted first (lkb=0, l_d=1, alu_ack with alu_n=0), then BYTE on the next IDLE sample.
- Byte load: byte_req only → exactly 1 cycle of lkb=1, l_d=1, byte_ack=1. busy high for 1 cycle, then IDLE.
- ALU repeat: alu_n=4'd5 → l_d=1, lkb=0 for 6 consecutive cycles. alu_ack only in the 6th cycle. alu_n=4'hF → 16 cycles.
- Arbitration: clr_req, byte_req and alu_req all held (each reasserted after its ack) → order is CLR, then alternation ALU, BYTE, ALU, BYTE. clr_d and l_d never overlap. CLR always wins when pending in IDLE.
- Non-preemption: clr_req raised in the 2nd cycle of a 4-cycle ALU sequence → ALU completes all 4 captures, then CLR follows after 1 IDLE cycle.
- Reset mid-sequence: _rst low in the 3rd cycle of alu_n=7 → l_d, busy and alu_ack go to 0 immediately. After release with no requests, the FSM stays IDLE with all outputs 0.

Source files
------------

// File: rtl/d_ctl.sv
// d_ctl: sequencer/arbiter for the 10-bit D register load path.
// Grants one of clear, byte-load and iterative ALU capture at a time and
// drives D's source select, load strobe and clear strobe (all registered).
module d_ctl #(
    parameter int unsigned ALU_N_W = 4
) (
    input  logic               clk_sys,
    input  logic               _rst,
    input  logic               clr_req,
    input  logic               byte_req,
    input  logic               alu_req,
    input  logic [0:ALU_N_W-1] alu_n,
    output logic               clr_ack,
    output logic               byte_ack,
    output logic               alu_ack,
    output logic               lkb,
    output logic               l_d,
    output logic               clr_d,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        BYTE,
        ALU
    } state_t;

    state_t             state;
    logic [ALU_N_W-1:0] cnt;
    // last: set on a BYTE grant, cleared on an ALU grant
    logic               last;
    // any_grant: low until the first BYTE/ALU grant after reset, so that
    // ALU has preference on a tie before any history exists
    logic               any_grant;
    logic               pick_alu;

    // Tie-break between byte and ALU: ALU wins unless it was granted last
    always_comb begin
        pick_alu = alu_req && (!byte_req || last || !any_grant);
    end

    // Main FSM with registered strobes, acks and busy
    always_ff @(posedge clk_sys or negedge _rst) begin
        if (!_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b0;
            any_grant <= 1'b0;
            lkb       <= 1'b0;
            l_d       <= 1'b0;
            clr_d     <= 1'b0;
            clr_ack   <= 1'b0;
            byte_ack  <= 1'b0;
            alu_ack   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            clr_ack  <= 1'b0;
            byte_ack <= 1'b0;
            alu_ack  <= 1'b0;
            clr_d    <= 1'b0;
            l_d      <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLR;
                        clr_d   <= 1'b1;
                        clr_ack <= 1'b1;
                        busy    <= 1'b1;
                    end else if (byte_req && !pick_alu) begin
                        state     <= BYTE;
                        lkb       <= 1'b1;
                        l_d       <= 1'b1;
                        byte_ack  <= 1'b1;
                        busy      <= 1'b1;
                        last      <= 1'b1;
                        any_grant <= 1'b1;
                    end else if (alu_req) begin
                        state     <= ALU;
                        cnt       <= alu_n;
                        lkb       <= 1'b0;
                        l_d       <= 1'b1;
                        alu_ack   <= (alu_n == '0);
                        busy      <= 1'b1;
                        last      <= 1'b0;
                        any_grant <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CLR, BYTE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ALU: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        // ack is registered, so it is raised one cycle ahead:
                        // it lands in the cycle where the counter reads 0
                        cnt     <= cnt - 1'b1;
                        l_d     <= 1'b1;
                        alu_ack <= (cnt == ALU_N_W'(1));
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_ctl.sv
// Bench for d_ctl: directed scenarios plus randomized requesters, checked
// against a transaction-level schedule model.
module tb_d_ctl;

    localparam int unsigned NW = 4;

    logic          clk_sys = 1'b0;
    logic          _rst;
    logic          clr_req, byte_req, alu_req;
    logic [0:NW-1] alu_n;
    logic          clr_ack, byte_ack, alu_ack, lkb, l_d, clr_d, busy;

    always #5 clk_sys = ~clk_sys;

    d_ctl #(.ALU_N_W(NW)) dut (
        .clk_sys (clk_sys),
        ._rst    (_rst),
        .clr_req (clr_req),
        .byte_req(byte_req),
        .alu_req (alu_req),
        .alu_n   (alu_n),
        .clr_ack (clr_ack),
        .byte_ack(byte_ack),
        .alu_ack (alu_ack),
        .lkb     (lkb),
        .l_d     (l_d),
        .clr_d   (clr_d),
        .busy    (busy)
    );

    typedef struct packed {
        logic clr_ack, byte_ack, alu_ack, lkb, l_d, clr_d, busy;
    } vec_t;

    typedef enum logic [1:0] {G_NONE, G_CLR, G_BYTE, G_ALU} grant_t;

    // Reference model: on an idle sample, a granted operation expands into
    // its full list of expected output cycles plus the trailing idle cycle.
    vec_t   sched[$];
    vec_t   expv;
    logic   m_lkb;
    grant_t m_last;
    grant_t grants[$];

    int     total = 0;
    int     bad   = 0;
    int     ld_cnt, ack_cnt;
    logic   p_clr, p_byte, p_alu, rnd_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic vec_t get_obs();
        get_obs = {clr_ack, byte_ack, alu_ack, lkb, l_d, clr_d, busy};
    endfunction

    task automatic model_reset();
        sched.delete();
        m_lkb  = 1'b0;
        m_last = G_NONE;
        expv   = '0;
    endtask

    task automatic model_edge();
        grant_t g;
        vec_t   v;
        int     n;
        if (sched.size() == 0) begin
            g = G_NONE;
            if (clr_req)                   g = G_CLR;
            else if (byte_req && alu_req)  g = (m_last == G_ALU) ? G_BYTE : G_ALU;
            else if (byte_req)             g = G_BYTE;
            else if (alu_req)              g = G_ALU;
            case (g)
                G_CLR: begin
                    v = '0; v.clr_d = 1'b1; v.clr_ack = 1'b1; v.busy = 1'b1; v.lkb = m_lkb;
                    sched.push_back(v);
                end
                G_BYTE: begin
                    m_lkb = 1'b1; m_last = G_BYTE;
                    v = '0; v.lkb = 1'b1; v.l_d = 1'b1; v.byte_ack = 1'b1; v.busy = 1'b1;
                    sched.push_back(v);
                end
                G_ALU: begin
                    m_lkb = 1'b0; m_last = G_ALU;
                    n = int'(alu_n);
                    for (int i = 0; i <= n; i++) begin
                        v = '0; v.l_d = 1'b1; v.busy = 1'b1; v.alu_ack = (i == n);
                        sched.push_back(v);
                    end
                end
                default: ;
            endcase
            if (g != G_NONE) begin
                grants.push_back(g);
                v = '0; v.lkb = m_lkb;
                sched.push_back(v);
            end
        end
        if (sched.size() > 0) expv = sched.pop_front();
        else begin
            expv = '0; expv.lkb = m_lkb;
        end
    endtask

    task automatic cycle();
        @(posedge clk_sys);
        if (_rst) model_edge();
        @(negedge clk_sys);
        check("outs", get_obs(), expv);
        check("excl", {31'd0, clr_d & l_d}, 32'd0);
        ld_cnt  += int'(l_d);
        ack_cnt += int'(alu_ack);
        // requesters drop on their ack, persistent ones re-raise a cycle later
        if (expv.clr_ack)        clr_req = 1'b0;
        else if (p_clr)          clr_req = 1'b1;
        if (expv.byte_ack)       byte_req = 1'b0;
        else if (p_byte)         byte_req = 1'b1;
        if (expv.alu_ack)        alu_req = 1'b0;
        else if (p_alu)          alu_req = 1'b1;
        if (rnd_mode) begin
            if (!clr_req && !expv.clr_ack && $urandom_range(0, 15) == 0) clr_req = 1'b1;
            if (!byte_req && !expv.byte_ack && $urandom_range(0, 3) == 0) byte_req = 1'b1;
            if (!alu_req && !expv.alu_ack && $urandom_range(0, 3) == 0) alu_req = 1'b1;
            if (byte_req && $urandom_range(0, 63) == 0) byte_req = 1'b0;
            if (alu_req && $urandom_range(0, 63) == 0) alu_req = 1'b0;
            alu_n = NW'($urandom);
        end
    endtask

    task automatic pulse_reset(input int cyc);
        _rst = 1'b0;
        clr_req = 1'b0; byte_req = 1'b0; alu_req = 1'b0;
        model_reset();
        #1 check("rst_async", get_obs(), 32'd0);
        repeat (cyc) begin
            @(posedge clk_sys);
            @(negedge clk_sys);
            check("rst_hold", get_obs(), 32'd0);
        end
        _rst = 1'b1;
    endtask

    grant_t arb_exp[5];

    initial begin
        arb_exp = '{G_CLR, G_ALU, G_BYTE, G_ALU, G_BYTE};
        p_clr = 1'b0; p_byte = 1'b0; p_alu = 1'b0; rnd_mode = 1'b0;
        ld_cnt = 0; ack_cnt = 0;
        clr_req = 1'b0; byte_req = 1'b0; alu_req = 1'b0; alu_n = '0;
        _rst = 1'b1;
        model_reset();
        #2 _rst = 1'b0;

        // reset held: toggling requests must not move any output
        repeat (6) begin
            @(negedge clk_sys);
            clr_req = 1'($urandom); byte_req = 1'($urandom); alu_req = 1'($urandom);
            #1 check("rst_idle", get_obs(), 32'd0);
        end
        @(negedge clk_sys);
        clr_req = 1'b0; byte_req = 1'b1; alu_req = 1'b1; alu_n = '0;
        _rst = 1'b1;
        grants.delete();
        repeat (6) cycle();
        check("rst_ngrants", grants.size(), 2);
        if (grants.size() >= 2) begin
            check("rst_first", grants[0], G_ALU);
            check("rst_second", grants[1], G_BYTE);
        end

        // single byte load
        byte_req = 1'b1; ld_cnt = 0;
        repeat (4) cycle();
        check("byte_ld", ld_cnt, 1);

        // ALU repeat counts 5 and 15
        alu_req = 1'b1; alu_n = 4'd5; ld_cnt = 0; ack_cnt = 0;
        cycle();
        alu_n = 4'd2;
        repeat (9) cycle();
        check("alu5_ld", ld_cnt, 6);
        check("alu5_ack", ack_cnt, 1);
        alu_req = 1'b1; alu_n = 4'hF; ld_cnt = 0; ack_cnt = 0;
        repeat (20) cycle();
        check("alu15_ld", ld_cnt, 16);
        check("alu15_ack", ack_cnt, 1);

        // arbitration with held requesters, from a fresh reset
        pulse_reset(1);
        alu_n = '0;
        clr_req = 1'b1; byte_req = 1'b1; alu_req = 1'b1;
        p_byte = 1'b1; p_alu = 1'b1;
        grants.delete();
        repeat (12) cycle();
        check("arb_ngrants_ge5", grants.size() >= 5, 1);
        for (int i = 0; i < 5; i++)
            if (i < grants.size()) check($sformatf("arb_order%0d", i), grants[i], arb_exp[i]);
        clr_req = 1'b1;
        repeat (8) cycle();
        p_byte = 1'b0; p_alu = 1'b0; byte_req = 1'b0; alu_req = 1'b0;
        repeat (6) cycle();

        // no preemption: clr raised during a 4-cycle ALU sequence
        alu_n = 4'd3; alu_req = 1'b1; grants.delete(); ld_cnt = 0;
        cycle();
        alu_n = 4'hC;
        cycle();
        clr_req = 1'b1;
        repeat (8) cycle();
        check("np_ld", ld_cnt, 4);
        check("np_ngrants", grants.size(), 2);
        if (grants.size() >= 2) begin
            check("np_first", grants[0], G_ALU);
            check("np_second", grants[1], G_CLR);
        end

        // reset in the 3rd cycle of an 8-cycle ALU sequence
        alu_n = 4'd7; alu_req = 1'b1; ack_cnt = 0;
        repeat (3) cycle();
        pulse_reset(2);
        repeat (5) cycle();
        check("mid_rst_ack", ack_cnt, 0);

        // randomized traffic with occasional resets
        rnd_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            cycle();
            if ($urandom_range(0, 399) == 0) pulse_reset(int'($urandom_range(1, 2)));
        end
        rnd_mode = 1'b0;
        clr_req = 1'b0; byte_req = 1'b0; alu_req = 1'b0;
        repeat (20) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
